kpn_adder_node: RTL and testbench

- KPN process node that consumes one 16-bit token from each of two upstream FIFOs, adds them, and pushes the sum into one downstream FIFO.
- Sits between FIFO stages in the KPN pipeline. Drives the FIFOs' rd/wr strobes and samples their data outputs.
- Blocking-read / blocking-write semantics: it fires only when both inputs hold data, and it stalls while the output is full.

---
 rtl/kpn_adder_node_if.sv | 31 +++
 rtl/kpn_adder_node.sv | 106 ++++++++++
 tb/tb_kpn_adder_node.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/kpn_adder_node_if.sv
// FIFO-facing bundle of the KPN adder node.
// master = node side, slave = FIFO side.
interface kpn_adder_node_if #(
  parameter int DATA_W = 16
);
  logic              empty_a;
  logic              empty_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              rd_a;
  logic              rd_b;
  logic              full_out;
  logic              wr_out;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  empty_a, empty_b,
    input  data_a, data_b,
    input  full_out,
    output rd_a, rd_b,
    output wr_out, data_out
  );

  modport slave (
    output empty_a, empty_b,
    output data_a, data_b,
    output full_out,
    input  rd_a, rd_b,
    input  wr_out, data_out
  );
endinterface

// File: rtl/kpn_adder_node.sv
// KPN node: pops one token from A and B, pushes A+B downstream.
// KPN_ADDER_SATURATE_EN: signed saturating add with sticky ovf.
module kpn_adder_node #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  kpn_adder_node_if.master bus,
  output logic [CNT_W-1:0] token_count,
  output logic             ovf
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WAIT_OUT,
    PUSH
  } state_t;

  state_t state;

  logic [DATA_W:0]   raw;
  logic [DATA_W-1:0] sum;
  logic              clamp;

  always_comb begin
    raw   = {1'b0, bus.data_a} + {1'b0, bus.data_b};
    sum   = raw[DATA_W-1:0];
    clamp = 1'b0;
`ifdef KPN_ADDER_SATURATE_EN
    // same-sign operands with a flipped result sign overflowed
    if (!bus.data_a[DATA_W-1] && !bus.data_b[DATA_W-1]
        && raw[DATA_W-1]) begin
      sum   = {1'b0, {(DATA_W-1){1'b1}}};
      clamp = 1'b1;
    end else if (bus.data_a[DATA_W-1] && bus.data_b[DATA_W-1]
                 && !raw[DATA_W-1]) begin
      sum   = {1'b1, {(DATA_W-1){1'b0}}};
      clamp = 1'b1;
    end
`endif
  end

`ifndef KPN_ADDER_SATURATE_EN
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus.rd_a     <= 1'b0;
      bus.rd_b     <= 1'b0;
      bus.wr_out   <= 1'b0;
      bus.data_out <= '0;
      token_count  <= '0;
`ifdef KPN_ADDER_SATURATE_EN
      ovf          <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.empty_a && !bus.empty_b) begin
            state    <= READ;
            bus.rd_a <= 1'b1;
            bus.rd_b <= 1'b1;
          end
        end
        READ: begin
          state    <= CAPTURE;
          bus.rd_a <= 1'b0;
          bus.rd_b <= 1'b0;
        end
        CAPTURE: begin
          bus.data_out <= sum;
`ifdef KPN_ADDER_SATURATE_EN
          if (clamp) ovf <= 1'b1;
`endif
          if (!bus.full_out) begin
            state      <= PUSH;
            bus.wr_out <= 1'b1;
          end else begin
            state <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (!bus.full_out) begin
            state      <= PUSH;
            bus.wr_out <= 1'b1;
          end
        end
        PUSH: begin
          state       <= IDLE;
          bus.wr_out  <= 1'b0;
          token_count <= token_count + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_clamp;
  assign unused_clamp = clamp ^ raw[DATA_W];

endmodule

// File: tb/tb_kpn_adder_node.sv
// Bench for kpn_adder_node: queue FIFO models, scoreboard monitor.
module tb_kpn_adder_node;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] token_count;
  logic        ovf;

  always #5 clk = ~clk;

  kpn_adder_node_if #(.DATA_W(16)) bus ();

  kpn_adder_node #(.DATA_W(16), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .token_count (token_count),
    .ovf         (ovf)
  );

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] exp_q[$];

  int errors = 0;
  int checks = 0;
  int cnt_model = 0;
  int ocnt = 0;
  int cyc = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  bit hold_full = 1'b0;
  bit drain_rand = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [15:0] ref_sum(logic [15:0] a, logic [15:0] b);
    int s;
`ifdef KPN_ADDER_SATURATE_EN
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s[15:0];
`else
    s = int'(a) + int'(b);
    s = s % 65536;
    return s[15:0];
`endif
  endfunction

  task automatic push_pair(logic [15:0] a, logic [15:0] b);
    qa.push_back(a);
    qb.push_back(b);
    exp_q.push_back(ref_sum(a, b));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rd(output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.rd_a) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) fail("rd_wait");
  endtask

  task automatic wait_wr(output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.wr_out) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) fail("wr_wait");
  endtask

  // upstream FIFOs deliver data the cycle after rd; downstream depth 4
  always @(posedge clk) begin
    cyc++;
    if (bus.rd_a && qa.size() > 0) bus.data_a <= qa.pop_front();
    if (bus.rd_b && qb.size() > 0) bus.data_b <= qb.pop_front();
    if (bus.wr_out) ocnt = ocnt + 1;
    if (ocnt > 0 && (!drain_rand || $urandom_range(0, 2) == 0))
      ocnt = ocnt - 1;
  end

  always @(negedge clk) begin
    bus.empty_a  <= (qa.size() == 0);
    bus.empty_b  <= (qb.size() == 0);
    bus.full_out <= hold_full || (ocnt >= 4);
  end

  logic [15:0] e;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_a || bus.rd_b) begin
        rd_seen++;
        chk("rd_pair", {31'd0, bus.rd_b}, {31'd0, bus.rd_a});
        chk("rd_wr_excl", {31'd0, bus.wr_out}, 32'd0);
      end
      if (bus.wr_out) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: data %0h, none expected",
                   bus.data_out);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", {16'd0, bus.data_out}, {16'd0, e});
        end
        chk("count_at_wr", {16'd0, token_count}, cnt_model);
        cnt_model = (cnt_model + 1) % 65536;
      end
    end
  end

  int t_rd, t_wr, t_f, r0, w0;
  logic [15:0] ra, rb;

  initial begin
    reset = 1'b1;
    repeat (3) step();
    chk("rst_rd", {31'd0, bus.rd_a}, 32'd0);
    chk("rst_wr", {31'd0, bus.wr_out}, 32'd0);
    chk("rst_data", {16'd0, bus.data_out}, 32'd0);
    chk("rst_count", {16'd0, token_count}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    reset = 1'b0;

    // both FIFOs empty: nothing fires
    r0 = rd_seen;
    w0 = wr_seen;
    repeat (20) step();
    chk("idle_rd", rd_seen - r0, 0);
    chk("idle_wr", wr_seen - w0, 0);
    chk("idle_count", {16'd0, token_count}, 32'd0);

    // basic token and latency
    push_pair(16'h0003, 16'h0004);
    wait_rd(t_rd);
    wait_wr(t_wr);
    chk("rd_to_wr", t_wr - t_rd, 2);
    chk("sum_7", {16'd0, bus.data_out}, 32'h7);
    step();
    chk("count_1", {16'd0, token_count}, 32'd1);
    chk("data_hold", {16'd0, bus.data_out}, 32'h7);

    // no partial read
    r0 = rd_seen;
    qa.push_back(16'h0005);
    repeat (10) step();
    chk("no_partial_rd", rd_seen - r0, 0);
    qb.push_back(16'h0010);
    exp_q.push_back(ref_sum(16'h0005, 16'h0010));
    wait_wr(t_wr);
    chk("sum_15", {16'd0, bus.data_out}, 32'h15);

    // output full stall
    hold_full = 1'b1;
    push_pair(16'h1000, 16'h2000);
    wait_rd(t_rd);
    step();
    w0 = wr_seen;
    repeat (6) step();
    chk("stall_no_wr", wr_seen - w0, 0);
    chk("stall_data", {16'd0, bus.data_out}, 32'h3000);
    hold_full = 1'b0;
    t_f = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!bus.full_out) begin
        t_f = cyc;
        break;
      end
    end
    if (t_f < 0) fail("full_fall");
    wait_wr(t_wr);
    chk("wr_after_full", t_wr - t_f, 1);

`ifdef KPN_ADDER_SATURATE_EN
    push_pair(16'h7FFF, 16'h0001);
    wait_wr(t_wr);
    chk("sat_pos", {16'd0, bus.data_out}, 32'h7FFF);
    step();
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    push_pair(16'h8000, 16'hFFFF);
    wait_wr(t_wr);
    chk("sat_neg", {16'd0, bus.data_out}, 32'h8000);
    push_pair(16'h0001, 16'h0001);
    wait_wr(t_wr);
    step();
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
`else
    push_pair(16'hFFFF, 16'h0002);
    wait_wr(t_wr);
    chk("wrap_sum", {16'd0, bus.data_out}, 32'h1);
    step();
    chk("ovf_zero", {31'd0, ovf}, 32'd0);
`endif

    // random traffic with random downstream drain
    drain_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        push_pair(ra, rb);
      end else begin
        qa.push_back(ra);
        repeat ($urandom_range(0, 6)) step();
        qb.push_back(rb);
        exp_q.push_back(ref_sum(ra, rb));
      end
      repeat ($urandom_range(0, 5)) step();
    end
    t_f = 0;
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) fail("drain");
    drain_rand = 1'b0;
    repeat (8) step();

    // reset while waiting on a full output
    hold_full = 1'b1;
    qa.push_back(16'h1111);
    qb.push_back(16'h2222);
    wait_rd(t_rd);
    repeat (3) step();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_rd", {31'd0, bus.rd_a}, 32'd0);
    chk("arst_wr", {31'd0, bus.wr_out}, 32'd0);
    chk("arst_data", {16'd0, bus.data_out}, 32'd0);
    chk("arst_count", {16'd0, token_count}, 32'd0);
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
    cnt_model = 0;
    hold_full = 1'b0;
    repeat (3) step();
    chk("arst_no_wr", {31'd0, bus.wr_out}, 32'd0);
    reset = 1'b0;
    push_pair(16'h0005, 16'h0006);
    wait_wr(t_wr);
    chk("post_rst_sum", {16'd0, bus.data_out}, 32'hB);
    step();
    chk("post_rst_count", {16'd0, token_count}, 32'd1);

    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
